// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: memory op encoding, bus size codes,
// FSM state type and small decode helpers.
package mem_pkg;

  localparam logic [3:0] MOP_NONE  = 4'd0;
  localparam logic [3:0] MOP_LD_B  = 4'd1;
  localparam logic [3:0] MOP_LD_H  = 4'd2;
  localparam logic [3:0] MOP_LD_W  = 4'd3;
  localparam logic [3:0] MOP_LD_BU = 4'd4;
  localparam logic [3:0] MOP_LD_HU = 4'd5;
  localparam logic [3:0] MOP_ST_B  = 4'd6;
  localparam logic [3:0] MOP_ST_H  = 4'd7;
  localparam logic [3:0] MOP_ST_W  = 4'd8;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_KREQ
  } state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op == MOP_LD_B) || (op == MOP_LD_H) || (op == MOP_LD_W) ||
           (op == MOP_LD_BU) || (op == MOP_LD_HU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MOP_ST_B) || (op == MOP_ST_H) || (op == MOP_ST_W);
  endfunction

  function automatic logic [1:0] op_size(input logic [3:0] op);
    logic [1:0] size;
    case (op)
      MOP_LD_H, MOP_LD_HU, MOP_ST_H: size = SIZE_H;
      MOP_LD_W, MOP_ST_W:            size = SIZE_W;
      default:                       size = SIZE_B;
    endcase
    return size;
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lo);
    logic ale;
    case (op)
      MOP_LD_H, MOP_LD_HU, MOP_ST_H: ale = lo[0];
      MOP_LD_W, MOP_ST_W:            ale = (lo != 2'b00);
      default:                       ale = 1'b0;
    endcase
    return ale;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: load byte/half extract with sign/zero extension,
// store byte strobes and lane replication.
module mem_align
  import mem_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_rdata = i_rdata;
    case (i_op)
      MOP_LD_B:  o_rdata = {{24{w_byte[7]}}, w_byte};
      MOP_LD_BU: o_rdata = {24'd0, w_byte};
      MOP_LD_H:  o_rdata = {{16{w_half[15]}}, w_half};
      MOP_LD_HU: o_rdata = {16'd0, w_half};
      default:   o_rdata = i_rdata;
    endcase
  end

  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = i_wdata;
    case (i_op)
      MOP_ST_B: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      MOP_ST_H: begin
        o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      MOP_ST_W: begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
      end
      default: begin
        o_wstrb = 4'b0000;
        o_wdata = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_sram.sv
// MEM pipeline stage on a split-handshake SRAM bus: one access per instruction,
// load alignment, ALE detection, and flush with cancelled-response tracking.
module mem_stage_sram
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int PASS_W = 70,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_allowin,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [PASS_W-1:0] in_pass,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PASS_W-1:0] out_pass,
  output logic [31:0]       out_result,
  output logic              out_ale,
  output logic [ADDR_W-1:0] out_badv,
  output logic              fwd_busy
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [3:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [PASS_W-1:0] r_pass;

  logic        w_accept;
  logic        w_ale;
  logic        w_mem;
  logic        w_load;
  logic        w_cnt_inc;
  logic        w_cnt_dec;
  logic        w_take_rdata;
  logic [31:0] w_load_data;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata_rep;

  assign w_ale  = misaligned(r_op, r_addr[1:0]);
  assign w_load = is_load(r_op);
  assign w_mem  = (is_load(r_op) | is_store(r_op)) & ~w_ale;

  assign in_allowin = ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready)) &
                      (r_cnt != CNT_MAX);
  assign w_accept   = in_valid & in_allowin & ~flush;

  // Responses arrive in order, so any data_ok while cancelled requests are
  // outstanding belongs to the oldest cancelled one.
  assign w_cnt_dec = data_data_ok & (r_cnt != CNT_ZERO);

  always_comb begin
    w_state_next = r_state;
    w_cnt_inc    = 1'b0;
    w_take_rdata = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_REQ;
      end
      S_REQ: begin
        if (flush) begin
          if (w_mem && data_addr_ok) begin
            w_state_next = S_IDLE;
            w_cnt_inc    = 1'b1;
          end else if (w_mem) begin
            w_state_next = S_KREQ;
          end else begin
            w_state_next = S_IDLE;
          end
        end else if (!w_mem) begin
          w_state_next = S_DONE;
        end else if (data_addr_ok) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          w_state_next = S_IDLE;
          // Our own response arriving with the flush retires it on the spot.
          w_cnt_inc    = ~(data_data_ok & (r_cnt == CNT_ZERO));
        end else if (data_data_ok && (r_cnt == CNT_ZERO)) begin
          w_state_next = S_DONE;
          w_take_rdata = 1'b1;
        end
      end
      S_KREQ: begin
        if (data_addr_ok) begin
          w_state_next = S_IDLE;
          w_cnt_inc    = 1'b1;
        end
      end
      S_DONE: begin
        if (flush)          w_state_next = S_IDLE;
        else if (out_ready) w_state_next = w_accept ? S_REQ : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_cnt_inc && !w_cnt_dec && (r_cnt != CNT_MAX)) w_cnt_next = r_cnt + CNT_ONE;
    else if (!w_cnt_inc && w_cnt_dec)                  w_cnt_next = r_cnt - CNT_ONE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
      r_op    <= MOP_NONE;
      r_addr  <= '0;
      r_data  <= '0;
      r_pass  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_op   <= in_op;
        r_addr <= in_addr;
        r_data <= in_wdata;
        r_pass <= in_pass;
      end else if (w_take_rdata && w_load) begin
        r_data <= w_load_data;
      end
    end
  end

  mem_align u_align (
    .i_op      (r_op),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_data),
    .i_rdata   (data_rdata),
    .o_wstrb   (w_wstrb),
    .o_wdata   (w_wdata_rep),
    .o_rdata   (w_load_data)
  );

  // KREQ keeps the request up with unchanged fields until the bus takes it.
  assign data_req   = ((r_state == S_REQ) & w_mem) | (r_state == S_KREQ);
  assign data_wr    = data_req & is_store(r_op);
  assign data_size  = op_size(r_op);
  assign data_addr  = r_addr;
  assign data_wstrb = w_wstrb;
  assign data_wdata = w_wdata_rep;

  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_data;
  assign out_pass   = r_pass;
  assign out_ale    = out_valid & w_ale;
  assign out_badv   = r_addr;
  assign fwd_busy   = w_load & ((r_state == S_REQ) | (r_state == S_WAIT));

endmodule
